sine_sample_collector: RTL

- Requesting end of the sample-generator handshake. On each sample-rate tick it pulses generate_next to a sample generator such as sine_reader, then waits for sample_ready and captures the 18-bit sample.
- Each captured sample is scaled and saturated to 16 bits, then queued in a small FIFO.
- Samples are presented to the codec/mixer side through a valid/ready interface.
- Also detects generator timeouts and dropped ticks.

---
 rtl/sine_sample_collector_pkg.sv | 18 +
 rtl/sample_fifo.sv | 61 ++++++
 rtl/sine_sample_collector.sv | 97 +++++++++
 3 files changed

// File: rtl/sine_sample_collector_pkg.sv
// Shared definitions for the sample collector: FSM encoding, 16-bit
// saturation limits and a saturating counter helper.
package sine_sample_collector_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small show-ahead FIFO; head entry is always visible on dout.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is only safe when the head leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // storage array, cleared so the head reads 0 out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       mem <= '0;
        else if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sine_sample_collector.sv
// Requests samples from a generator on each tick, scales and saturates
// them to 16 bits and queues them for a valid/ready consumer.
module sine_sample_collector
    import sine_sample_collector_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SHIFT   = 0,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    output logic               generate_next,
    input  logic               sample_ready,
    input  logic signed [17:0] sample,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_sample,
    output logic               timeout_err,
    output logic [7:0]         drop_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic signed [17:0] MAX18 = $signed({{2{SAT_MAX[15]}}, SAT_MAX});
    localparam logic signed [17:0] MIN18 = $signed({{2{SAT_MIN[15]}}, SAT_MIN});

    state_t             state;
    logic [7:0]         wait_cnt;
    logic signed [17:0] shifted;
    logic [15:0]        sat_val;
    logic               push;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;

    assign shifted = sample >>> SHIFT;
    // only a strobe answering our own request is captured
    assign push    = (state == WAIT) && sample_ready;

    // clamp the shifted sample into the signed 16-bit range
    always_comb begin
        sat_val = shifted[15:0];
        if (shifted > MAX18)      sat_val = SAT_MAX;
        else if (shifted < MIN18) sat_val = SAT_MIN;
    end

    // request/wait FSM with registered request pulse, error and drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            generate_next <= 1'b0;
            timeout_err   <= 1'b0;
            drop_count    <= '0;
        end else begin
            generate_next <= 1'b0;
            case (state)
                IDLE: begin
                    // the slot checked here stays reserved: nothing else pushes
                    if (sample_tick && (fifo_count < CNT_W'(DEPTH))) begin
                        generate_next <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= WAIT;
                    end else if (sample_tick && fifo_full) begin
                        drop_count <= sat_inc8(drop_count);
                    end
                end
                WAIT: begin
                    if (sample_tick) drop_count <= sat_inc8(drop_count);
                    if (sample_ready) begin
                        state <= IDLE;
                    end else if (wait_cnt == 8'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sample_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (out_ready),
        .din   (sat_val),
        .dout  (out_sample),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;

endmodule
